// File: rtl/sb_alloc_ctrl_pkg.sv
// Shared types and sizing for the scoreboard allocation controller.
// Functional-unit encoding, per-entry state encoding and the pointer-increment helper.
package sb_alloc_ctrl_pkg;

  localparam int NR_SB_ENTRIES = 4;
  localparam int TRANS_ID_BITS = 2;
  localparam int NR_WB_PORTS   = 3;

  typedef enum logic [3:0] {
    NONE      = 4'd0,
    LOAD      = 4'd1,
    STORE     = 4'd2,
    ALU       = 4'd3,
    CTRL_FLOW = 4'd4,
    MULT      = 4'd5,
    CSR       = 4'd6,
    FPU       = 4'd7
  } fu_t;

  typedef enum logic [1:0] {
    SB_FREE   = 2'd0,
    SB_ISSUED = 2'd1,
    SB_DONE   = 2'd2
  } sb_state_t;

  // Ring-pointer increment that wraps at nr_entries-1 rather than at 2**TRANS_ID_BITS-1.
  function automatic logic [TRANS_ID_BITS-1:0] ptr_inc(input logic [TRANS_ID_BITS-1:0] p,
                                                       input int nr_entries);
    return (p == TRANS_ID_BITS'(nr_entries - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/sb_entry_fsm.sv
// One scoreboard slot: FREE -> ISSUED -> DONE -> FREE lifecycle plus stored fu and exception flag.
// Flush beats everything; a commit beats a writeback, so a bypassed commit from ISSUED still frees the slot.
module sb_entry_fsm
  import sb_alloc_ctrl_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      flush_i,
  input  logic      alloc_i,
  input  fu_t       alloc_fu_i,
  input  logic      wb_i,
  input  logic      wb_ex_i,
  input  logic      commit_i,
  output sb_state_t state_o,
  output fu_t       fu_o,
  output logic      ex_o
);

  sb_state_t state_q, state_d;
  fu_t       fu_q, fu_d;
  logic      ex_q, ex_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SB_FREE;
      fu_q    <= NONE;
      ex_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fu_q    <= fu_d;
      ex_q    <= ex_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fu_d    = fu_q;
    ex_d    = ex_q;
    if (flush_i) begin
      state_d = SB_FREE;
      fu_d    = NONE;
      ex_d    = 1'b0;
    end else begin
      case (state_q)
        SB_FREE: begin
          if (alloc_i) begin
            state_d = SB_ISSUED;
            fu_d    = alloc_fu_i;
            ex_d    = 1'b0;
          end
        end
        SB_ISSUED: begin
          if (commit_i) begin
            state_d = SB_FREE;
          end else if (wb_i) begin
            state_d = SB_DONE;
            ex_d    = ex_q | wb_ex_i;
          end
        end
        SB_DONE: begin
          if (commit_i) state_d = SB_FREE;
        end
        default: state_d = SB_FREE;
      endcase
    end
  end

  always_comb begin
    state_o = state_q;
    fu_o    = fu_q;
    ex_o    = ex_q;
  end

endmodule

// File: rtl/sb_alloc_ctrl.sv
// Scoreboard transaction-ID allocator: in-order alloc at tail, out-of-order writeback, in-order commit at head.
// Define SB_ALLOC_WB_BYPASS_EN to let a writeback to an ISSUED head entry raise commit_valid_o in the same cycle.
module sb_alloc_ctrl
  import sb_alloc_ctrl_pkg::*;
#(
  parameter int NR_ENTRIES = NR_SB_ENTRIES,
  parameter int NR_WB      = NR_WB_PORTS
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic                              alloc_req_i,
  input  fu_t                               alloc_fu_i,
  output logic                              alloc_gnt_o,
  output logic [TRANS_ID_BITS-1:0]          alloc_id_o,
  input  logic [NR_WB-1:0]                  wb_valid_i,
  input  logic [NR_WB*TRANS_ID_BITS-1:0]    wb_id_i,
  input  logic [NR_WB-1:0]                  wb_ex_i,
  output logic                              commit_valid_o,
  output logic [TRANS_ID_BITS-1:0]          commit_id_o,
  output fu_t                               commit_fu_o,
  output logic                              commit_ex_o,
  input  logic                              commit_ack_i,
  output logic                              full_o,
  output logic                              empty_o,
  output logic [TRANS_ID_BITS:0]            cnt_o
);

  localparam int IW = TRANS_ID_BITS;

  logic [IW-1:0]         head_q, tail_q;
  logic [IW:0]           cnt_q;
  logic                  gnt, commit_fire;
  logic [NR_ENTRIES-1:0] wb_hit, wb_ex_hit, ent_alloc, ent_commit;
  sb_state_t             ent_state [NR_ENTRIES];
  fu_t                   ent_fu    [NR_ENTRIES];
  logic                  ent_ex    [NR_ENTRIES];

  // Registered count only: a same-cycle commit does not open a slot for allocation.
  assign full_o  = (cnt_q == (IW+1)'(NR_ENTRIES));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;

  assign gnt         = alloc_req_i & ~full_o & ~flush_i & rst_ni;
  assign alloc_gnt_o = gnt;
  assign alloc_id_o  = tail_q;
  assign commit_id_o = head_q;
  assign commit_fu_o = ent_fu[head_q];
  assign commit_fire = commit_valid_o & commit_ack_i;

  // Several ports may hit one entry; their exception bits are ORed.
  always_comb begin
    wb_hit    = '0;
    wb_ex_hit = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      for (int k = 0; k < NR_WB; k++) begin
        if (wb_valid_i[k] && (wb_id_i[k*IW +: IW] == IW'(i))) begin
          wb_hit[i]    = 1'b1;
          wb_ex_hit[i] = wb_ex_hit[i] | wb_ex_i[k];
        end
      end
    end
  end

`ifdef SB_ALLOC_WB_BYPASS_EN
  logic bypass;
  assign bypass         = wb_hit[head_q] & (ent_state[head_q] == SB_ISSUED);
  assign commit_valid_o = rst_ni & ~flush_i & ((ent_state[head_q] == SB_DONE) | bypass);
  assign commit_ex_o    = rst_ni & (bypass ? (wb_ex_hit[head_q] | ent_ex[head_q]) : ent_ex[head_q]);
`else
  assign commit_valid_o = rst_ni & ~flush_i & (ent_state[head_q] == SB_DONE);
  assign commit_ex_o    = ent_ex[head_q];
`endif

  always_comb begin
    ent_alloc  = '0;
    ent_commit = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      ent_alloc[i]  = gnt & (tail_q == IW'(i));
      ent_commit[i] = commit_fire & (head_q == IW'(i));
    end
  end

  for (genvar g = 0; g < NR_ENTRIES; g++) begin : g_entry
    sb_entry_fsm u_entry (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (flush_i),
      .alloc_i    (ent_alloc[g]),
      .alloc_fu_i (alloc_fu_i),
      .wb_i       (wb_hit[g]),
      .wb_ex_i    (wb_ex_hit[g]),
      .commit_i   (ent_commit[g]),
      .state_o    (ent_state[g]),
      .fu_o       (ent_fu[g]),
      .ex_o       (ent_ex[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (gnt)         tail_q <= ptr_inc(tail_q, NR_ENTRIES);
      if (commit_fire) head_q <= ptr_inc(head_q, NR_ENTRIES);
      case ({gnt, commit_fire})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_alloc_ctrl.sv
// Directed table-driven bench for sb_alloc_ctrl; expectations adapt when SB_ALLOC_WB_BYPASS_EN is defined.
module tb_sb_alloc_ctrl;
  import sb_alloc_ctrl_pkg::*;

`ifdef SB_ALLOC_WB_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush, alloc_req, alloc_gnt, commit_valid, commit_ex, commit_ack, full, empty;
  fu_t        alloc_fu, commit_fu;
  logic [1:0] alloc_id, commit_id;
  logic [2:0] wb_valid, wb_ex, cnt;
  logic [5:0] wb_id;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       flush;
    logic       req;
    fu_t        fu;
    logic [2:0] wbv;
    logic [5:0] wbid;
    logic [2:0] wbex;
    logic       ack;
    logic       gnt;
    logic [1:0] aid;
    logic       cv;
    logic [1:0] cid;
    fu_t        cfu;
    logic       cex;
    logic       full;
    logic       empty;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[$];

  sb_alloc_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .alloc_req_i    (alloc_req),
    .alloc_fu_i     (alloc_fu),
    .alloc_gnt_o    (alloc_gnt),
    .alloc_id_o     (alloc_id),
    .wb_valid_i     (wb_valid),
    .wb_id_i        (wb_id),
    .wb_ex_i        (wb_ex),
    .commit_valid_o (commit_valid),
    .commit_id_o    (commit_id),
    .commit_fu_o    (commit_fu),
    .commit_ex_o    (commit_ex),
    .commit_ack_i   (commit_ack),
    .full_o         (full),
    .empty_o        (empty),
    .cnt_o          (cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int fl, int rq, fu_t fu, int wbv, int wbid, int wbex, int ack,
                              int gnt, int aid, int cv, int cid, fu_t cfu, int cex,
                              int fu_full, int emp, int cn);
    vec_t v;
    v.flush = 1'(fl);   v.req  = 1'(rq);   v.fu   = fu;       v.wbv  = 3'(wbv);
    v.wbid  = 6'(wbid); v.wbex = 3'(wbex); v.ack  = 1'(ack);  v.gnt  = 1'(gnt);
    v.aid   = 2'(aid);  v.cv   = 1'(cv);   v.cid  = 2'(cid);  v.cfu  = cfu;
    v.cex   = 1'(cex);  v.full = 1'(fu_full); v.empty = 1'(emp); v.cnt = 3'(cn);
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    flush = 1'b0; alloc_req = 1'b0; alloc_fu = NONE; commit_ack = 1'b0;
    wb_valid = '0; wb_id = '0; wb_ex = '0;
  endtask

  task automatic check_outputs(input int idx, input vec_t v);
    chk("alloc_gnt",    idx, 8'(alloc_gnt),    8'(v.gnt));
    chk("alloc_id",     idx, 8'(alloc_id),     8'(v.aid));
    chk("commit_valid", idx, 8'(commit_valid), 8'(v.cv));
    chk("commit_id",    idx, 8'(commit_id),    8'(v.cid));
    chk("commit_fu",    idx, 8'(commit_fu),    8'(v.cfu));
    chk("commit_ex",    idx, 8'(commit_ex),    8'(v.cex));
    chk("full",         idx, 8'(full),         8'(v.full));
    chk("empty",        idx, 8'(empty),        8'(v.empty));
    chk("cnt",          idx, 8'(cnt),          8'(v.cnt));
  endtask

  initial begin
    // flush req fu wbv wbid wbex ack | gnt aid cv cid cfu cex full empty cnt
    // Fill to full, fifth request refused
    vecs.push_back(mk(0,1,ALU,  0,0,0,0, 1,0,0,0,NONE,0,0,1,0));
    vecs.push_back(mk(0,1,LOAD, 0,0,0,0, 1,1,0,0,ALU, 0,0,0,1));
    vecs.push_back(mk(0,1,STORE,0,0,0,0, 1,2,0,0,ALU, 0,0,0,2));
    vecs.push_back(mk(0,1,MULT, 0,0,0,0, 1,3,0,0,ALU, 0,0,0,3));
    vecs.push_back(mk(0,1,CSR,  0,0,0,0, 0,0,0,0,ALU, 0,1,0,4));
    // Full: writeback head, then commit + request same cycle, regrant ID 0 next cycle
    vecs.push_back(mk(0,0,NONE, 3'b001,6'h00,0,0, 0,0,BYP,0,ALU,0,1,0,4));
    vecs.push_back(mk(0,1,CSR,  0,0,0,1, 0,0,1,0,ALU, 0,1,0,4));
    vecs.push_back(mk(0,1,CSR,  0,0,0,0, 1,0,0,1,LOAD,0,0,0,3));
    vecs.push_back(mk(0,0,NONE, 0,0,0,0, 0,1,0,1,LOAD,0,1,0,4));
    // ID 1 written back on ports 0 (ex=0) and 2 (ex=1) together
    vecs.push_back(mk(0,0,NONE, 3'b101,6'b01_00_01,3'b100,0, 0,1,BYP,1,LOAD,BYP,1,0,4));
    vecs.push_back(mk(0,0,NONE, 0,0,0,1, 0,1,1,1,LOAD, 1,1,0,4));
    vecs.push_back(mk(0,0,NONE, 0,0,0,0, 0,1,0,2,STORE,0,0,0,3));
    // Flush with 3 issued, plus request and writeback in the flush cycle
    vecs.push_back(mk(1,1,ALU,  3'b001,6'h00,3'b001,0, 0,1,0,2,STORE,0,0,0,3));
    vecs.push_back(mk(0,1,LOAD, 0,0,0,0, 1,0,0,0,NONE,0,0,1,0));
    // Out-of-order writeback: 2 then 0; 1 held until its own writeback
    vecs.push_back(mk(0,1,ALU,  0,0,0,0, 1,1,0,0,LOAD,0,0,0,1));
    vecs.push_back(mk(0,1,STORE,0,0,0,0, 1,2,0,0,LOAD,0,0,0,2));
    vecs.push_back(mk(0,0,NONE, 3'b010,6'b00_10_00,0,0, 0,3,0,0,LOAD,0,0,0,3));
    vecs.push_back(mk(0,0,NONE, 3'b001,6'h00,3'b001,0, 0,3,BYP,0,LOAD,BYP,0,0,3));
    vecs.push_back(mk(0,0,NONE, 0,0,0,0, 0,3,1,0,LOAD, 1,0,0,3));
    vecs.push_back(mk(0,0,NONE, 0,0,0,1, 0,3,1,0,LOAD, 1,0,0,3));
    vecs.push_back(mk(0,0,NONE, 0,0,0,0, 0,3,0,1,ALU,  0,0,0,2));
    vecs.push_back(mk(0,0,NONE, 0,0,0,1, 0,3,0,1,ALU,  0,0,0,2));
    vecs.push_back(mk(0,0,NONE, 3'b100,6'b01_00_00,0,0, 0,3,BYP,1,ALU,0,0,0,2));
    vecs.push_back(mk(0,0,NONE, 0,0,0,1, 0,3,1,1,ALU,  0,0,0,2));
    vecs.push_back(mk(0,0,NONE, 0,0,0,1, 0,3,1,2,STORE,0,0,0,1));
    // Tail wraps 3 -> 0; simultaneous grant and commit keeps cnt
    vecs.push_back(mk(0,1,CSR,  0,0,0,0, 1,3,0,3,NONE,0,0,1,0));
    vecs.push_back(mk(0,0,NONE, 3'b001,6'b00_00_11,0,0, 0,0,BYP,3,CSR,0,0,0,1));
    vecs.push_back(mk(0,1,ALU,  0,0,0,1, 1,0,1,3,CSR, 0,0,0,1));
    vecs.push_back(mk(0,0,NONE, 0,0,0,0, 0,1,0,0,ALU, 0,0,0,1));

    // Reset values, with a pending request that must not be granted
    drive_idle();
    rst_n     = 1'b0;
    alloc_req = 1'b1;
    #3;
    check_outputs(-1, mk(0,1,ALU,0,0,0,0, 0,0,0,0,NONE,0,0,1,0));
    repeat (2) @(negedge clk);
    drive_idle();
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      flush      = vecs[i].flush;
      alloc_req  = vecs[i].req;
      alloc_fu   = vecs[i].fu;
      wb_valid   = vecs[i].wbv;
      wb_id      = vecs[i].wbid;
      wb_ex      = vecs[i].wbex;
      commit_ack = vecs[i].ack;
      #2;
      check_outputs(i, vecs[i]);
    end

    // Mid-operation asynchronous reset clears everything without a clock edge
    @(negedge clk);
    drive_idle();
    alloc_req = 1'b1;
    alloc_fu  = MULT;
    #1 rst_n = 1'b0;
    #1;
    check_outputs(100, mk(0,1,MULT,0,0,0,0, 0,0,0,0,NONE,0,0,1,0));
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check_outputs(101, mk(0,1,MULT,0,0,0,0, 1,0,0,0,NONE,0,0,1,0));
    @(negedge clk);
    drive_idle();
    #2;
    check_outputs(102, mk(0,0,NONE,0,0,0,0, 0,1,0,0,MULT,0,0,0,1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sb_alloc_ctrl.md
SB_ALLOC_CTRL -- requirements
Module: sb_alloc_ctrl

Interface
REQ-001 SHALL have parameter NR_ENTRIES, default NR_SB_ENTRIES (4): number of scoreboard slots; power of two, at least 2.
REQ-002 SHALL have parameter NR_WB, default NR_WB_PORTS (3): number of writeback ports.
REQ-003 SHALL have one clock, clk_i, input, 1 bit; all state is updated on its rising edge.
REQ-004 SHALL have reset rst_ni, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have flush_i, input, 1 bit: discard all in-flight entries.
REQ-006 SHALL have alloc_req_i, input, 1 bit (issue requests a transaction ID), and alloc_fu_i, input, fu_t, 4 bits (functional unit of the issuing instruction).
REQ-007 SHALL have alloc_gnt_o, output, 1 bit, and alloc_id_o, output, TRANS_ID_BITS (the ID being granted).
REQ-008 SHALL have wb_valid_i, input, NR_WB bits; wb_id_i, input, NR_WB*TRANS_ID_BITS; wb_ex_i, input, NR_WB bits (the result carries an exception).
REQ-009 SHALL have the following commit-side outputs, all driven by the head entry: commit_valid_o, 1 bit; commit_id_o, TRANS_ID_BITS; commit_fu_o, fu_t; commit_ex_o, 1 bit.
REQ-010 SHALL have commit_ack_i, input, 1 bit: commit consumes the head entry.
REQ-011 SHALL have full_o and empty_o, outputs, 1 bit each, and cnt_o, output, TRANS_ID_BITS+1 (occupied entries).

Function
REQ-012 SHALL give each entry a state FREE, ISSUED or DONE, plus a stored fu_t and exception flag.
REQ-013 SHALL allocate in order at tail pointer and commit in order at head pointer; both pointers are TRANS_ID_BITS wide and wrap from NR_ENTRIES-1 to 0.
REQ-014 SHALL drive alloc_gnt_o = alloc_req_i & !full_o & !flush_i and alloc_id_o = tail, both combinationally.
REQ-015 SHALL, on a grant, move entry[tail] FREE->ISSUED, store alloc_fu_i, clear its exception flag and advance tail; the new state is visible from the next cycle.
REQ-016 SHALL, for each wb_valid_i[k] whose target entry is ISSUED, move that entry ISSUED->DONE and OR wb_ex_i[k] into its exception flag.
REQ-017 SHALL ignore a writeback that targets a FREE or DONE entry; if two ports target the same entry in one cycle, the exception flags are ORed.
REQ-018 SHALL drive commit_valid_o = (entry[head] == DONE) & !flush_i, with commit_id_o = head.
REQ-019 SHALL, when commit_valid_o & commit_ack_i, move entry[head] DONE->FREE and advance head; commit_ack_i without commit_valid_o is ignored.
REQ-020 SHALL compute full_o = (cnt == NR_ENTRIES) and empty_o = (cnt == 0) from the registered count; a commit in the same cycle does not free a slot for allocation in that cycle.
REQ-021 SHALL leave cnt unchanged on simultaneous grant and commit, increment it on grant only, and decrement it on commit only.
REQ-022 SHALL give flush_i priority over every other event: next cycle all entries are FREE, head = tail = cnt = 0, and alloc and writeback in the flush cycle are discarded.
REQ-023 SHALL have a minimum latency of 1 cycle from writeback to commit_valid_o, and 2 cycles from alloc to commit.

Reset
REQ-024 SHALL, while rst_ni is low, hold all entries FREE with head = tail = cnt = 0, stored fu = NONE and exception flags = 0.
REQ-025 SHALL, while rst_ni is low, drive alloc_gnt_o = 0, commit_valid_o = 0, commit_ex_o = 0, empty_o = 1, full_o = 0 and all IDs = 0.
REQ-026 SHALL treat reset asserted mid-operation exactly like flush_i, taking effect asynchronously.

Configuration
REQ-027 SHALL provide macro SB_ALLOC_WB_BYPASS_EN: when defined, a writeback to the head entry while that entry is ISSUED raises commit_valid_o in the same cycle, with commit_ex_o taken from the writeback; when undefined, REQ-023 latency applies and there is no combinational path from wb_* to commit_*.

Structure
REQ-028 SHALL add sb_state_t (SB_FREE, SB_ISSUED, SB_DONE) to the shared package and reuse the package's NR_SB_ENTRIES, TRANS_ID_BITS, NR_WB_PORTS and fu_t.
REQ-029 SHALL implement the per-entry state, fu and exception storage as one sub-module, sb_entry_fsm, instantiated NR_ENTRIES times; pointers, count and bypass logic live in the top module.

Verification
REQ-030 Fill: 4 allocs on back-to-back cycles -> IDs 0,1,2,3 granted; full_o=1, cnt_o=4; a 5th request gets alloc_gnt_o=0.
REQ-031 Out-of-order writeback: alloc 0..2; writeback ID 2 then ID 0 -> commit_valid_o for ID 0 only, then ID 1 held until its writeback, then ID 2.
REQ-032 Wrap and concurrency: with full_o=1, commit ID 0 and request in the same cycle -> no grant; next cycle ID 0 is granted again, cnt_o=4.
REQ-033 Exception: writeback ID 1 on port 0 (ex=0) and port 2 (ex=1) in the same cycle -> commit_ex_o=1 when ID 1 commits.
REQ-034 Flush: 3 entries ISSUED, flush_i plus a writeback to ID 0 -> next cycle empty_o=1, commit_valid_o=0, next grant returns ID 0.
REQ-035 Bypass: writeback head ID 0 -> commit_valid_o in the same cycle with SB_ALLOC_WB_BYPASS_EN defined, one cycle later without it.
